// File: rtl/mul_bus_slave_pkg.sv
// Purpose : shared definitions for the multiplier bus slave (offsets, bit indices, FSM states).
// Latency : n/a (definitions only).
// Backpressure: n/a.
package mul_bus_slave_pkg;

  // Word offsets decoded from the low four address bits
  localparam logic [3:0] ADDR_OPA     = 4'h0;
  localparam logic [3:0] ADDR_OPB     = 4'h1;
  localparam logic [3:0] ADDR_CTRL    = 4'h2;
  localparam logic [3:0] ADDR_STATUS  = 4'h3;
  localparam logic [3:0] ADDR_RES_LO  = 4'h4;
  localparam logic [3:0] ADDR_RES_HI  = 4'h5;
  localparam logic [3:0] ADDR_INT_EN  = 4'h6;
  localparam logic [3:0] ADDR_CYCLES  = 4'h7;

  // CTRL / STATUS bit positions
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int CTRL_ACK_BIT    = 2;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } fsm_state_e;

  typedef struct packed {
    logic ack;
    logic abort;
    logic start;
  } ctrl_cmd_t;

  function automatic ctrl_cmd_t decode_ctrl(input logic [31:0] wdat);
    ctrl_cmd_t c;
    c.start = wdat[CTRL_START_BIT];
    c.abort = wdat[CTRL_ABORT_BIT];
    c.ack   = wdat[CTRL_ACK_BIT];
    return c;
  endfunction

endpackage

// File: rtl/mul_slave_fsm.sv
// Purpose : run-control FSM for the multiplier core: IDLE -> RUN -> CLEAR -> IDLE, plus RUN-cycle counter.
// Latency : start accepted on an edge -> op_start high after that edge; op_done/abort -> op_clear after the edge.
// Backpressure: none; start is only honoured in IDLE, abort only in RUN.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   start_i, abort_i         qualified CTRL write commands from the register file
//   op_done_i                completion strobe from the core
//   state_o                  current state (busy = state != IDLE)
//   op_start_o, op_clear_o   registered core controls
//   capture_o                result capture enable (combinational, RUN & op_done & !abort)
//   cycles_o                 saturating count of cycles spent in RUN
module mul_slave_fsm
  import mul_bus_slave_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             op_done_i,
  output fsm_state_e       state_o,
  output logic             op_start_o,
  output logic             op_clear_o,
  output logic             capture_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fsm_state_e       state_q;
  logic             op_start_q;
  logic             op_clear_q;
  logic [CNT_W-1:0] cycles_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_start_q <= 1'b0;
      op_clear_q <= 1'b0;
      cycles_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Abort in the same write as start keeps us idle
          if (start_i && !abort_i) begin
            state_q    <= ST_RUN;
            op_start_q <= 1'b1;
            cycles_q   <= '0;
          end
        end
        ST_RUN: begin
          // Count every edge spent in RUN, including the exit edge
          if (cycles_q != '1) begin
            cycles_q <= cycles_q + CNT_ONE;
          end
          if (abort_i || op_done_i) begin
            state_q    <= ST_CLEAR;
            op_start_q <= 1'b0;
            op_clear_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_q    <= ST_IDLE;
          op_clear_q <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          op_start_q <= 1'b0;
          op_clear_q <= 1'b0;
        end
      endcase
    end
  end

  // Abort has priority over a coincident op_done: no capture
  assign capture_o  = (state_q == ST_RUN) && op_done_i && !abort_i;
  assign state_o    = state_q;
  assign op_start_o = op_start_q;
  assign op_clear_o = op_clear_q;
  assign cycles_o   = cycles_q;

endmodule

// File: rtl/mul_bus_slave.sv
// Purpose : bus register front end for the sequential signed multiplier core (operands, control, result, irq).
// Latency : register writes take effect on the write edge; reads are combinational; result visible one edge after op_done.
// Backpressure: none; writes to operands or start while busy are silently dropped.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   s_sel, s_wr, s_addr, s_din, s_dout simple select/write bus; s_dout is 0 unless reading
//   m_interrupt                        level interrupt = DONE & INT_EN
//   multiplicand, multiplier           operand registers to the core
//   op_start, op_clear                 core controls
//   op_done, mul_result                core completion and 64-bit product
module mul_bus_slave
  import mul_bus_slave_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [31:0]       s_din,
  output logic [31:0]       s_dout,
  output logic              m_interrupt,
  output logic [31:0]       multiplicand,
  output logic [31:0]       multiplier,
  output logic              op_start,
  output logic              op_clear,
  input  logic              op_done,
  input  logic [63:0]       mul_result
);

  logic [3:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic       busy;
  logic       ctrl_wr;
  ctrl_cmd_t  cmd;
  logic       start_req;
  logic       abort_req;
  logic       start_go;
  logic       ack_req;
  logic       capture;
  fsm_state_e state;
  logic [CNT_W-1:0] cycles;

  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [63:0] res_q, res_d;
  logic        done_q, done_d;
  logic        int_en_q, int_en_d;

  // Upper address bits are deliberately not decoded
  logic unused_addr_hi;
  assign unused_addr_hi = ^s_addr[ADDR_W-1:4];

  assign addr  = s_addr[3:0];
  assign wr_en = s_sel && s_wr;
  assign rd_en = s_sel && !s_wr;
  assign busy  = (state != ST_IDLE);

  assign ctrl_wr   = wr_en && (addr == ADDR_CTRL);
  assign cmd       = decode_ctrl(s_din);
  assign start_req = ctrl_wr && cmd.start && !busy;
  assign abort_req = ctrl_wr && cmd.abort;
  assign start_go  = start_req && !abort_req;
  // A write carrying start never acts as done_ack, even if the start is dropped
  assign ack_req   = ctrl_wr && cmd.ack && !cmd.start;

  mul_slave_fsm #(.CNT_W(CNT_W)) u_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (start_req),
    .abort_i    (abort_req),
    .op_done_i  (op_done),
    .state_o    (state),
    .op_start_o (op_start),
    .op_clear_o (op_clear),
    .capture_o  (capture),
    .cycles_o   (cycles)
  );

  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    done_d   = done_q;
    int_en_d = int_en_q;

    if (wr_en && !busy && (addr == ADDR_OPA)) opa_d = s_din;
    if (wr_en && !busy && (addr == ADDR_OPB)) opb_d = s_din;
    if (wr_en && (addr == ADDR_INT_EN))       int_en_d = s_din[0];

    if (ack_req || start_go) done_d = 1'b0;
    // A completion landing on the same edge as an ack still reports DONE
    if (capture) begin
      res_d  = mul_result;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      int_en_q <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      done_q   <= done_d;
      int_en_q <= int_en_d;
    end
  end

  always_comb begin
    s_dout = '0;
    if (rd_en) begin
      case (addr)
        ADDR_OPA:    s_dout = opa_q;
        ADDR_OPB:    s_dout = opb_q;
        ADDR_STATUS: begin
          s_dout[STATUS_BUSY_BIT] = busy;
          s_dout[STATUS_DONE_BIT] = done_q;
        end
        ADDR_RES_LO: s_dout = res_q[31:0];
        ADDR_RES_HI: s_dout = res_q[63:32];
        ADDR_INT_EN: s_dout = {31'd0, int_en_q};
        ADDR_CYCLES: s_dout = 32'(cycles);
        default:     s_dout = '0;
      endcase
    end
  end

  assign m_interrupt  = done_q && int_en_q;
  assign multiplicand = opa_q;
  assign multiplier   = opb_q;

endmodule
